// File: rtl/key_event_if.sv
// Key level in, event pulses and busy out, between the key-event classifier and its user.
interface key_event_if;
  logic key_in;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  modport master (
    output key_in,
    input  press_pulse, release_pulse, short_press, long_press, double_click, busy
  );

  modport slave (
    input  key_in,
    output press_pulse, release_pulse, short_press, long_press, double_click, busy
  );
endinterface

// File: rtl/key_event.sv
// Classifies a debounced key level into press/release edges and short, long and double-click events.
module key_event #(
  parameter int unsigned LONG_CNT = 1000,
  parameter int unsigned GAP_CNT  = 250
) (
  input  logic        clk,
  input  logic        rst,
  key_event_if.slave  ev
);

  localparam int unsigned MAX_CNT = (LONG_CNT > GAP_CNT) ? LONG_CNT : GAP_CNT;
  localparam int          CW      = $clog2(MAX_CNT);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HOLD,
    WAIT_GAP,
    PRESS2
  } state_t;

  state_t        state;
  logic          key_d;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] gap_cnt;
  logic          rise;
  logic          fall;

  assign rise = ev.key_in & ~key_d;
  assign fall = ~ev.key_in & key_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      key_d            <= 1'b0;
      hold_cnt         <= '0;
      gap_cnt          <= '0;
      ev.press_pulse   <= 1'b0;
      ev.release_pulse <= 1'b0;
      ev.short_press   <= 1'b0;
      ev.long_press    <= 1'b0;
      ev.double_click  <= 1'b0;
      ev.busy          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every branch below read the pre-edge
      // state and counters; the pulse defaults here are overridden by at most one branch.
      key_d            <= ev.key_in;
      ev.press_pulse   <= 1'b0;
      ev.release_pulse <= fall;
      ev.short_press   <= 1'b0;
      ev.long_press    <= 1'b0;
      ev.double_click  <= 1'b0;
      ev.busy          <= (state != IDLE);

      case (state)
        IDLE: begin
          if (rise) begin
            state          <= PRESS1;
            hold_cnt       <= '0;
            ev.press_pulse <= 1'b1;
          end
        end

        PRESS1: begin
          if (fall) begin
            state   <= WAIT_GAP;
            gap_cnt <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            state         <= LONG_HOLD;
            ev.long_press <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
        end

        WAIT_GAP: begin
          // A rise on the timeout edge still starts the second press.
          if (rise) begin
            state          <= PRESS2;
            hold_cnt       <= '0;
            ev.press_pulse <= 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            state          <= IDLE;
            ev.short_press <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + CNT_ONE;
          end
        end

        PRESS2: begin
          if (fall) begin
            state           <= IDLE;
            ev.double_click <= 1'b1;
          end else if (hold_cnt == LONG_LAST) begin
            state         <= LONG_HOLD;
            ev.long_press <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + CNT_ONE;
          end
        end

        LONG_HOLD: begin
          if (fall) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Random and directed stimulus for key_event, checked every cycle against a timestamp-based event model.
module tb_key_event;

  localparam int LONG_CNT = 8;
  localparam int GAP_CNT  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  key_event_if ev ();

  key_event #(.LONG_CNT(LONG_CNT), .GAP_CNT(GAP_CNT)) dut (
    .clk (clk),
    .rst (rst),
    .ev  (ev)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks which phase of a gesture the key is in, and the edge index of
  // the last accepted press and last release; thresholds are measured as elapsed edges.
  typedef enum {M_IDLE, M_FIRST, M_LONG, M_GAP, M_SECOND} phase_t;

  phase_t     ph       = M_IDLE;
  bit         m_kd     = 1'b0;
  int         m_k      = 0;
  int         press_at = 0;
  int         fall_at  = 0;
  logic [5:0] exp_v    = '0;   // {press, release, short, long, double, busy}

  int q_press[$];
  int q_rel[$];
  int q_short[$];
  int q_long[$];
  int q_dbl[$];
  int last_busy = -1;

  function automatic logic [5:0] dut_vec();
    return {ev.press_pulse, ev.release_pulse, ev.short_press,
            ev.long_press, ev.double_click, ev.busy};
  endfunction

  task automatic model_step(input bit key);
    bit rise, fall;
    bit p, s, l, d, b;
    rise = key && !m_kd;
    fall = !key && m_kd;
    p = 0; s = 0; l = 0; d = 0;
    b = (ph != M_IDLE);
    case (ph)
      M_IDLE:   if (rise) begin ph = M_FIRST; press_at = m_k; p = 1; end
      M_FIRST:  if (fall) begin ph = M_GAP; fall_at = m_k; end
                else if (m_k - press_at == LONG_CNT) begin ph = M_LONG; l = 1; end
      M_GAP:    if (rise) begin ph = M_SECOND; press_at = m_k; p = 1; end
                else if (m_k - fall_at == GAP_CNT) begin ph = M_IDLE; s = 1; end
      M_SECOND: if (fall) begin ph = M_IDLE; d = 1; end
                else if (m_k - press_at == LONG_CNT) begin ph = M_LONG; l = 1; end
      M_LONG:   if (fall) ph = M_IDLE;
      default:  ph = M_IDLE;
    endcase
    m_kd  = key;
    exp_v = {p, fall, s, l, d, b};
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        ph    = M_IDLE;
        m_kd  = 1'b0;
        exp_v = '0;
        #1 check("reset_outputs", 32'(dut_vec()), 32'(6'b0));
      end else begin
        model_step(ev.key_in);
        #1 check("cycle_outputs", 32'(dut_vec()), 32'(exp_v));
        if (ev.press_pulse)   q_press.push_back(m_k);
        if (ev.release_pulse) q_rel.push_back(m_k);
        if (ev.short_press)   q_short.push_back(m_k);
        if (ev.long_press)    q_long.push_back(m_k);
        if (ev.double_click)  q_dbl.push_back(m_k);
        if (ev.busy)          last_busy = m_k;
        m_k++;
      end
    end
  end

  task automatic clear_log();
    q_press.delete(); q_rel.delete(); q_short.delete();
    q_long.delete(); q_dbl.delete();
    last_busy = -1;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  // Called at a falling edge: drive the level, then let n rising edges sample it.
  task automatic hold(input bit v, input int n);
    ev.key_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    ev.key_in = 1'b0;
    repeat (3) @(negedge clk);
    check("initial_reset_state", 32'(dut_vec()), 32'(6'b0));
    rst = 1'b1;
    hold(0, 3);

    // Short press: high 3, then low.
    clear_log();
    hold(1, 3); hold(0, 12);
    check("short_release_lat", at(q_rel, 0) - at(q_press, 0), 3);
    check("short_press_lat",   at(q_short, 0) - at(q_press, 0), 7);
    check("short_busy_last",   last_busy - at(q_press, 0), 7);
    check("short_count", q_short.size(), 1);
    check("short_no_long_dbl", q_long.size() + q_dbl.size(), 0);

    // Long press: held 20 cycles.
    clear_log();
    hold(1, 20); hold(0, 6);
    check("long_press_lat",   at(q_long, 0) - at(q_press, 0), 8);
    check("long_release_lat", at(q_rel, 0) - at(q_press, 0), 20);
    check("long_count", q_long.size(), 1);
    check("long_no_short_dbl", q_short.size() + q_dbl.size(), 0);

    // Double click: high 2, low 2, high 2, low.
    clear_log();
    hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 8);
    check("dbl_press_count", q_press.size(), 2);
    check("dbl_release_count", q_rel.size(), 2);
    check("dbl_with_release2", at(q_dbl, 0), at(q_rel, 1));
    check("dbl_no_short", q_short.size(), 0);

    // Second rise exactly GAP_CNT edges after the first fall still counts.
    clear_log();
    hold(1, 2); hold(0, 4); hold(1, 2); hold(0, 8);
    check("gap4_rise_offset", at(q_press, 1) - at(q_rel, 0), 4);
    check("gap4_no_short", q_short.size(), 0);
    check("gap4_double", q_dbl.size(), 1);

    // One edge later: short press first, then a fresh first press.
    clear_log();
    hold(1, 2); hold(0, 5); hold(1, 2); hold(0, 10);
    check("gap5_short_lat", at(q_short, 0) - at(q_rel, 0), 4);
    check("gap5_rise_offset", at(q_press, 1) - at(q_rel, 0), 5);
    check("gap5_no_double", q_dbl.size(), 0);
    check("gap5_short_count", q_short.size(), 2);

    // Reset during the gap, released with the key held.
    clear_log();
    hold(1, 2); hold(0, 1);
    #2 rst = 1'b0;
    #1 check("reset_async_clear", 32'(dut_vec()), 32'(6'b0));
    ev.key_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2 check("reset_press_first_edge", at(q_press, q_press.size() - 1), m_k - 1);
    @(negedge clk);
    hold(1, 1); hold(0, 10);
    check("reset_short_count", q_short.size(), 1);
    check("reset_short_from_new", at(q_short, 0) - at(q_rel, 1), 4);

    // Random gestures with occasional reset pulses.
    begin
      bit lvl = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 39) == 0) begin
          #2 rst = 1'b0;
          ev.key_in = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 3)) @(negedge clk);
          rst = 1'b1;
        end
        lvl = ~lvl;
        hold(lvl, $urandom_range(1, 12));
      end
    end
    hold(0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
